// File: rtl/isa_io_master.sv
// isa_io_master
//   Turns single-byte read/write commands from a local controller into ISA
//   I/O bus cycles (address/AEN setup, IOR#/IOW# strobe, IOCHRDY wait states,
//   hold and recovery).
//
// Ports
//   clk, reset_l          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_write             1 = IOW cycle, 0 = IOR cycle
//   cmd_addr, cmd_wdata   16-bit I/O port address, write byte
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             read byte (0xFF after a ready timeout)
//   rsp_timeout           cycle was aborted because IOCHRDY never returned
//   bus_a                 20-bit ISA address, upper nibble always zero
//   bus_ior_l, bus_iow_l  active-low I/O strobes
//   bus_aen, bus_ale      address enable (low during own cycles), latch pulse
//   bus_d_out, bus_d_oe   write data to the pad and its output enable
//   bus_d_in              read data from the pad
//   bus_rdy               IOCHRDY, asynchronous to clk
module isa_io_master #(
  parameter int unsigned SETUP_CYCLES    = 2,
  parameter int unsigned STROBE_CYCLES   = 6,
  parameter int unsigned HOLD_CYCLES     = 2,
  parameter int unsigned RECOVERY_CYCLES = 2,
  parameter int unsigned RDY_TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic [19:0] bus_a,
  output logic        bus_ior_l,
  output logic        bus_iow_l,
  output logic        bus_aen,
  output logic        bus_ale,
  output logic [7:0]  bus_d_out,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_d_in,
  input  logic        bus_rdy
);

  // Counter reload values: the counter runs N-1 .. 0, so a state lasts N cycles.
  localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LD  = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LD    = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] RECOVER_LD = 8'(RECOVERY_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LD = 8'(RDY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_STROBE,
    S_WAIT_RDY,
    S_HOLD,
    S_RECOVER
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic        rdy_meta_q, rdy_s_q;

  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [19:0] bus_a_q, bus_a_d;
  logic        bus_ior_l_q, bus_ior_l_d;
  logic        bus_iow_l_q, bus_iow_l_d;
  logic        bus_aen_q, bus_aen_d;
  logic        bus_ale_q, bus_ale_d;
  logic [7:0]  bus_d_out_q, bus_d_out_d;
  logic        bus_d_oe_q, bus_d_oe_d;

  logic [7:0]  cnt_dec;
  logic        strobe_on;
  logic        drive_data;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    write_d       = write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    bus_a_d       = bus_a_q;
    bus_d_out_d   = bus_d_out_q;
    cnt_dec       = cnt_q - 8'd1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d       = S_ADDR;
          cnt_d         = SETUP_LD;
          write_d       = cmd_write;
          bus_a_d       = {4'h0, cmd_addr};
          rsp_timeout_d = 1'b0;
          if (cmd_write) begin
            bus_d_out_d = cmd_wdata;
          end
        end
      end
      S_ADDR: begin
        if (cnt_q == 8'd0) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_STROBE: begin
        if (cnt_q == 8'd0) begin
          if (rdy_s_q) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LD;
            if (!write_q) begin
              rsp_rdata_d = bus_d_in;
            end
          end else begin
            state_d = S_WAIT_RDY;
            cnt_d   = TIMEOUT_LD;
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_WAIT_RDY: begin
        // Ready is tested before the timeout so a late IOCHRDY still completes normally.
        if (rdy_s_q) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
          if (!write_q) begin
            rsp_rdata_d = bus_d_in;
          end
        end else if (cnt_q == 8'd0) begin
          state_d       = S_HOLD;
          cnt_d         = HOLD_LD;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = 8'hFF;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = S_RECOVER;
          cnt_d   = RECOVER_LD;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_RECOVER: begin
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // Bus outputs are decoded from the next state so they are registered
    // yet line up exactly with the state they belong to.
    strobe_on   = (state_d == S_STROBE) || (state_d == S_WAIT_RDY);
    drive_data  = (state_d == S_ADDR) || strobe_on || (state_d == S_HOLD);
    cmd_ready_d = (state_d == S_IDLE);
    bus_aen_d   = (state_d == S_IDLE) || (state_d == S_RECOVER);
    bus_ale_d   = (state_q == S_IDLE) && (state_d == S_ADDR);
    bus_ior_l_d = !(strobe_on && !write_d);
    bus_iow_l_d = !(strobe_on && write_d);
    bus_d_oe_d  = write_d && drive_data;
    rsp_valid_d = (state_q == S_RECOVER) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      write_q       <= 1'b0;
      rdy_meta_q    <= 1'b1;
      rdy_s_q       <= 1'b1;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 8'h00;
      rsp_timeout_q <= 1'b0;
      bus_a_q       <= 20'h00000;
      bus_ior_l_q   <= 1'b1;
      bus_iow_l_q   <= 1'b1;
      bus_aen_q     <= 1'b1;
      bus_ale_q     <= 1'b0;
      bus_d_out_q   <= 8'h00;
      bus_d_oe_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      // Two-flop synchroniser for the asynchronous IOCHRDY input.
      rdy_meta_q    <= bus_rdy;
      rdy_s_q       <= rdy_meta_q;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      bus_a_q       <= bus_a_d;
      bus_ior_l_q   <= bus_ior_l_d;
      bus_iow_l_q   <= bus_iow_l_d;
      bus_aen_q     <= bus_aen_d;
      bus_ale_q     <= bus_ale_d;
      bus_d_out_q   <= bus_d_out_d;
      bus_d_oe_q    <= bus_d_oe_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign bus_a       = bus_a_q;
  assign bus_ior_l   = bus_ior_l_q;
  assign bus_iow_l   = bus_iow_l_q;
  assign bus_aen     = bus_aen_q;
  assign bus_ale     = bus_ale_q;
  assign bus_d_out   = bus_d_out_q;
  assign bus_d_oe    = bus_d_oe_q;

endmodule

// File: tb/tb_isa_io_master.sv
// Testbench for isa_io_master: directed scenarios plus randomized commands,
// IOCHRDY stretches and pad data, checked every cycle against a timeline model.
module tb_isa_io_master;
  localparam int S  = 2;
  localparam int ST = 6;
  localparam int H  = 2;
  localparam int R  = 2;
  localparam int T  = 16;

  logic        clk = 1'b0;
  logic        reset_l = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = 16'h0;
  logic [7:0]  cmd_wdata = 8'h0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic [19:0] bus_a;
  logic        bus_ior_l, bus_iow_l, bus_aen, bus_ale, bus_d_oe;
  logic [7:0]  bus_d_out;
  logic [7:0]  bus_d_in = 8'h0;
  logic        bus_rdy = 1'b1;

  isa_io_master #(
    .SETUP_CYCLES(S), .STROBE_CYCLES(ST), .HOLD_CYCLES(H),
    .RECOVERY_CYCLES(R), .RDY_TIMEOUT(T)
  ) dut (
    .clk(clk), .reset_l(reset_l),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .bus_a(bus_a), .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
    .bus_aen(bus_aen), .bus_ale(bus_ale), .bus_d_out(bus_d_out),
    .bus_d_oe(bus_d_oe), .bus_d_in(bus_d_in), .bus_rdy(bus_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pad-side driver: IOCHRDY and read data change shortly after each edge.
  bit         rand_mode = 1'b0;
  bit         rdy_req = 1'b1;
  bit         din_fixed = 1'b0;
  logic [7:0] din_val = 8'h0;
  int         burst = 0;
  always @(posedge clk) begin
    #2;
    if (rand_mode) begin
      if (burst > 0) begin
        bus_rdy <= 1'b0;
        burst   <= burst - 1;
      end else if ($urandom_range(0, 9) == 0) begin
        bus_rdy <= 1'b0;
        burst   <= $urandom_range(0, 24);
      end else begin
        bus_rdy <= 1'b1;
      end
    end else begin
      bus_rdy <= rdy_req;
    end
    bus_d_in <= din_fixed ? din_val : 8'($urandom);
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Model: one command at a time, described by its accept cycle and the
  // relative cycle at which the strobe ends (0 while still unresolved).
  bit          m_busy = 1'b0;
  int          m_ca = 0;
  bit          m_wr = 1'b0;
  logic [7:0]  m_wdata = 8'h0;
  int          m_end = 0;
  bit          m_to = 1'b0;
  logic [7:0]  m_rdata = 8'h0;
  logic [19:0] m_bus_a = 20'h0;
  int          m_lat = 0;
  bit          rdy_low_hist [65536];

  // Observations of the DUT used by the directed scenarios.
  bit          seen_ready = 1'b0;
  int          dut_ale_last = 0, dut_ale_prev = 0, dut_rsp_cnt = 0, dut_rsp_cyc = 0;
  int          ior_cnt = 0, iow_cnt = 0, doe_cnt = 0;
  logic [7:0]  dut_rdata = 8'h0;
  logic        dut_to = 1'b0;

  task automatic tick();
    bit idle, e_rsp, ah, str, hold, rec, rs;
    int t, c2, ci;
    @(negedge clk);
    ci = cyc;
    rdy_low_hist[ci[15:0]] = !bus_rdy;
    c2 = cyc - 2;
    rs = (cyc < 2) ? 1'b1 : !rdy_low_hist[c2[15:0]];

    seen_ready = cmd_ready;
    if (bus_ale) begin dut_ale_prev = dut_ale_last; dut_ale_last = cyc; end
    if (!bus_ior_l) ior_cnt++;
    if (!bus_iow_l) iow_cnt++;
    if (bus_d_oe) doe_cnt++;
    if (rsp_valid) begin
      dut_rsp_cnt++;
      dut_rsp_cyc = cyc;
      dut_rdata   = rsp_rdata;
      dut_to      = rsp_timeout;
    end
    chk("dual_strobe", 32'(!bus_ior_l && !bus_iow_l), 0);
    chk("strobe_while_aen", 32'((!bus_ior_l || !bus_iow_l) && bus_aen), 0);

    if (!reset_l) begin
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      chk("rst_bus_a", bus_a, 0);
      chk("rst_ior_l", bus_ior_l, 1);
      chk("rst_iow_l", bus_iow_l, 1);
      chk("rst_aen", bus_aen, 1);
      chk("rst_ale", bus_ale, 0);
      chk("rst_d_out", bus_d_out, 0);
      chk("rst_d_oe", bus_d_oe, 0);
      m_busy  = 1'b0;
      m_bus_a = 20'h0;
    end else begin
      idle = !m_busy; e_rsp = 0; ah = 0; str = 0; hold = 0; rec = 0;
      t = cyc - m_ca;
      if (m_busy) begin
        if (m_end == 0) begin
          if (t <= S) ah = 1; else str = 1;
        end else if (t <= m_end) str = 1;
        else if (t <= m_end + H) hold = 1;
        else if (t <= m_end + H + R) rec = 1;
        else begin idle = 1; e_rsp = 1; end
      end
      chk("cmd_ready", cmd_ready, idle);
      chk("rsp_valid", rsp_valid, e_rsp);
      chk("bus_aen", bus_aen, 32'(idle || rec));
      chk("bus_ale", bus_ale, 32'(m_busy && !idle && t == 1));
      chk("bus_ior_l", bus_ior_l, 32'(!(str && !m_wr)));
      chk("bus_iow_l", bus_iow_l, 32'(!(str && m_wr)));
      chk("bus_d_oe", bus_d_oe, 32'(m_wr && (ah || str || hold)));
      chk("bus_a", bus_a, m_bus_a);
      if (m_wr && (ah || str || hold)) chk("bus_d_out", bus_d_out, m_wdata);
      if (e_rsp) begin
        chk("rsp_timeout", rsp_timeout, m_to);
        if (m_to || !m_wr) chk("rsp_rdata", rsp_rdata, m_rdata);
        m_busy = 1'b0;
        m_lat  = t;
      end
      // Resolve the end of the strobe from the synchronised ready history.
      if (str && m_end == 0 && t >= S + ST) begin
        if (rs) begin
          m_end = t;
          if (!m_wr) m_rdata = bus_d_in;
        end else if (t - (S + ST) == T) begin
          m_end   = t;
          m_to    = 1'b1;
          m_rdata = 8'hFF;
        end
      end
      if (idle && cmd_valid) begin
        m_busy  = 1'b1;
        m_ca    = cyc;
        m_wr    = cmd_write;
        m_wdata = cmd_wdata;
        m_end   = 0;
        m_to    = 1'b0;
        m_bus_a = {4'h0, cmd_addr};
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit w, input logic [15:0] a, input logic [7:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    do begin
      tick();
      n++;
    end while (!seen_ready && n < 200);
    chk("send_accept", seen_ready, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n, c0;
    n = 0;
    c0 = dut_rsp_cnt;
    while (dut_rsp_cnt == c0 && n < 100) begin
      tick();
      n++;
    end
    chk("rsp_seen", dut_rsp_cnt - c0, 1);
  endtask

  initial begin
    int b_ior, b_iow, b_doe, b_rsp, g, s;
    bit w;
    logic [15:0] a;
    logic [7:0] d;

    #1 reset_l = 1'b0;
    repeat (3) tick();
    reset_l = 1'b1;
    repeat (2) tick();

    // Write 0x388 <- 0x20 with ready high.
    b_ior = ior_cnt; b_iow = iow_cnt; b_doe = doe_cnt;
    send(1'b1, 16'h0388, 8'h20);
    wait_rsp();
    chk("wr_latency", dut_rsp_cyc - dut_ale_last + 1, 13);
    chk("wr_model_latency", m_lat, 13);
    chk("wr_iow_cycles", iow_cnt - b_iow, 6);
    chk("wr_ior_cycles", ior_cnt - b_ior, 0);
    chk("wr_doe_cycles", doe_cnt - b_doe, 10);
    chk("wr_timeout", dut_to, 0);
    repeat (3) tick();

    // Read 0x389 with 0x5A on the pad.
    din_fixed = 1'b1; din_val = 8'h5A;
    b_ior = ior_cnt; b_doe = doe_cnt;
    send(1'b0, 16'h0389, 8'h00);
    wait_rsp();
    chk("rd_rdata", dut_rdata, 8'h5A);
    chk("rd_timeout", dut_to, 0);
    chk("rd_ior_cycles", ior_cnt - b_ior, 6);
    chk("rd_doe_cycles", doe_cnt - b_doe, 0);
    chk("rd_latency", dut_rsp_cyc - dut_ale_last + 1, 13);
    repeat (2) tick();

    // Read stretched by IOCHRDY low from cycle 4 for 10 cycles.
    din_val = 8'hC3;
    b_ior = ior_cnt;
    send(1'b0, 16'h0389, 8'h00);
    repeat (3) tick();
    rdy_req = 1'b0;
    repeat (10) tick();
    rdy_req = 1'b1;
    wait_rsp();
    chk("wait_latency", dut_rsp_cyc - dut_ale_last + 1, 21);
    chk("wait_model_latency", m_lat, 21);
    chk("wait_rdata", dut_rdata, 8'hC3);
    chk("wait_timeout", dut_to, 0);
    chk("wait_ior_cycles", ior_cnt - b_ior, 14);
    repeat (2) tick();

    // IOCHRDY stuck low: timeout abort, then a normal read.
    rdy_req = 1'b0;
    repeat (3) tick();
    b_ior = ior_cnt;
    send(1'b0, 16'h0200, 8'h00);
    wait_rsp();
    chk("to_timeout", dut_to, 1);
    chk("to_rdata", dut_rdata, 8'hFF);
    chk("to_latency", dut_rsp_cyc - dut_ale_last + 1, 29);
    chk("to_model_latency", m_lat, 29);
    chk("to_ior_cycles", ior_cnt - b_ior, 22);
    rdy_req = 1'b1;
    din_val = 8'h5A;
    repeat (4) tick();
    send(1'b0, 16'h0389, 8'h00);
    wait_rsp();
    chk("after_to_timeout", dut_to, 0);
    chk("after_to_rdata", dut_rdata, 8'h5A);
    chk("after_to_latency", dut_rsp_cyc - dut_ale_last + 1, 13);
    repeat (2) tick();

    // Back-to-back write then read with cmd_valid held.
    b_rsp = dut_rsp_cnt;
    send(1'b1, 16'h0388, 8'h11);
    send(1'b0, 16'h0389, 8'h00);
    wait_rsp();
    chk("b2b_ale_spacing", dut_ale_last - dut_ale_prev, 13);
    chk("b2b_rsp_count", dut_rsp_cnt - b_rsp, 2);
    chk("b2b_rdata", dut_rdata, 8'h5A);
    repeat (2) tick();

    // Reset asserted during cycle 5 of a write.
    b_rsp = dut_rsp_cnt;
    send(1'b1, 16'h0388, 8'h77);
    repeat (4) tick();
    chk("pre_rst_iow", bus_iow_l, 0);
    #2 reset_l = 1'b0;
    #1;
    chk("async_rst_iow", bus_iow_l, 1);
    chk("async_rst_aen", bus_aen, 1);
    chk("async_rst_doe", bus_d_oe, 0);
    chk("async_rst_ready", cmd_ready, 1);
    tick();
    reset_l = 1'b1;
    repeat (20) tick();
    chk("rst_no_rsp", dut_rsp_cnt - b_rsp, 0);
    chk("rst_ready_after", cmd_ready, 1);

    // Randomized commands, gaps, IOCHRDY stretches and pad data.
    din_fixed = 1'b0;
    rand_mode = 1'b1;
    b_rsp = dut_rsp_cnt;
    for (int i = 0; i < 300; i++) begin
      g = $urandom_range(0, 3);
      repeat (g) tick();
      w = 1'($urandom_range(0, 1));
      s = $urandom_range(0, 3);
      a = (s == 0) ? 16'h0388 : (s == 1) ? 16'h0389 : 16'($urandom);
      d = 8'($urandom);
      send(w, a, d);
    end
    rand_mode = 1'b0;
    repeat (60) tick();
    chk("rand_rsp_count", dut_rsp_cnt - b_rsp, 300);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
